// File: rtl/dcache_pkg.sv
// Shared definitions for the 2-way set-associative data-cache sequencer:
// field widths, address slicing, SRAM tag layout and the controller state type.
package dcache_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int LINE_W      = 256;
  localparam int IDX_W       = 4;
  localparam int TAG_W       = 23;
  localparam int STAG_W      = TAG_W + 2;
  localparam int OFF_W       = 5;
  localparam int WSEL_W      = 3;
  localparam int WSEL_LSB    = 2;
  localparam int LINE_ADDR_W = ADDR_W - OFF_W;
  localparam int VALID_BIT   = 24;
  localparam int DIRTY_BIT   = 23;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MISS      = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_FETCH     = 3'd3,
    ST_REFILL    = 3'd4
  } dc_state_e;

  function automatic logic [STAG_W-1:0] make_stag(input logic valid, input logic dirty,
                                                    input logic [TAG_W-1:0] tag);
    return {valid, dirty, tag};
  endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// CPU, memory and SRAM-side signals of the data-cache sequencer.
// The master modport is the controller's view.
interface dcache_controller_if;
  import dcache_pkg::*;

  logic                  cpu_req_i;
  logic                  cpu_we_i;
  logic [ADDR_W-1:0]     cpu_addr_i;
  logic [WORD_W-1:0]     cpu_data_i;
  logic [WORD_W-1:0]     cpu_data_o;
  logic                  cpu_stall_o;
  logic                  mem_enable_o;
  logic                  mem_write_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [LINE_W-1:0]     mem_data_o;
  logic [LINE_W-1:0]     mem_data_i;
  logic                  mem_ack_i;
  logic                  sram_enable_o;
  logic                  sram_write_o;
  logic [IDX_W-1:0]      sram_addr_o;
  logic [STAG_W-1:0]     sram_tag_o;
  logic [LINE_W-1:0]     sram_data_o;
  logic [STAG_W-1:0]     sram_tag_i;
  logic [LINE_W-1:0]     sram_data_i;
  logic                  sram_hit_i;

  modport master (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
           sram_tag_i, sram_data_i, sram_hit_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
           sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o, sram_data_o
  );

  modport slave (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
           sram_tag_i, sram_data_i, sram_hit_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
           sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o, sram_data_o
  );

endinterface

// File: rtl/dcache_word_merge.sv
// Selects one word out of a cache line and builds the line with that word
// replaced by store data.
module dcache_word_merge #(
  parameter int LINE_W = 256,
  parameter int WORD_W = 32,
  parameter int SEL_W  = $clog2(LINE_W / WORD_W)
) (
  input  logic [LINE_W-1:0] line_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] word_o,
  output logic [LINE_W-1:0] line_o
);

  assign word_o = line_i[WORD_W*sel_i +: WORD_W];

  // Store merge: copy the line and overwrite the selected word.
  always_comb begin
    line_o                        = line_i;
    line_o[WORD_W*sel_i +: WORD_W] = word_i;
  end

endmodule

// File: rtl/dcache_controller.sv
// Data-cache sequencer: serves hits combinationally, and on a miss writes back a
// dirty victim, fetches the missing line and installs it clean.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  dcache_controller_if.master  bus
);

  dc_state_e               state_r;
  logic [LINE_ADDR_W-1:0]  line_r;
  logic [LINE_W-1:0]       refill_r;
  logic                    mem_enable_r;
  logic                    mem_write_r;
  logic [ADDR_W-1:0]       mem_addr_r;
  logic [LINE_W-1:0]       mem_data_r;

  logic                    idle_s;
  logic [LINE_ADDR_W-1:0]  cur_line_s;
  logic [WORD_W-1:0]       rd_word_s;
  logic [LINE_W-1:0]       merged_s;
  logic                    st_en_s;

  // Outside IDLE the CPU may have withdrawn its request, so the latched line address wins.
  assign idle_s     = (state_r == ST_IDLE);
  assign cur_line_s = idle_s ? bus.cpu_addr_i[ADDR_W-1:OFF_W] : line_r;
  assign st_en_s    = bus.cpu_req_i & bus.cpu_we_i;

  dcache_word_merge #(
    .LINE_W (LINE_W),
    .WORD_W (WORD_W),
    .SEL_W  (WSEL_W)
  ) u_merge (
    .line_i (bus.sram_data_i),
    .sel_i  (bus.cpu_addr_i[WSEL_LSB +: WSEL_W]),
    .word_i (bus.cpu_data_i),
    .word_o (rd_word_s),
    .line_o (merged_s)
  );

  assign bus.sram_enable_o = bus.cpu_req_i | ~idle_s;
  assign bus.sram_addr_o   = cur_line_s[IDX_W-1:0];
  assign bus.cpu_stall_o   = ~idle_s | (bus.cpu_req_i & ~bus.sram_hit_i);
  assign bus.mem_enable_o  = mem_enable_r;
  assign bus.mem_write_o   = mem_write_r;
  assign bus.mem_addr_o    = mem_addr_r;
  assign bus.mem_data_o    = mem_data_r;

  // Tag word to compare/write; kept independent of the hit flag so the SRAM path has no loop.
  always_comb begin
    if (idle_s) begin
      bus.sram_tag_o = make_stag(st_en_s, st_en_s, cur_line_s[LINE_ADDR_W-1:IDX_W]);
    end else if (state_r == ST_REFILL) begin
      bus.sram_tag_o = make_stag(1'b1, 1'b0, cur_line_s[LINE_ADDR_W-1:IDX_W]);
    end else begin
      bus.sram_tag_o = make_stag(1'b0, 1'b0, cur_line_s[LINE_ADDR_W-1:IDX_W]);
    end
  end

  // Hit service and refill write strobes.
  always_comb begin
    bus.cpu_data_o   = {WORD_W{1'b0}};
    bus.sram_write_o = 1'b0;
    bus.sram_data_o  = {LINE_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (bus.cpu_req_i && bus.sram_hit_i && bus.cpu_we_i) begin
          bus.sram_write_o = 1'b1;
          bus.sram_data_o  = merged_s;
        end else if (bus.cpu_req_i && bus.sram_hit_i) begin
          bus.cpu_data_o = rd_word_s;
        end else begin
          bus.cpu_data_o = {WORD_W{1'b0}};
        end
      end
      ST_REFILL: begin
        bus.sram_write_o = 1'b1;
        bus.sram_data_o  = refill_r;
      end
      default: begin
        bus.sram_write_o = 1'b0;
      end
    endcase
  end

  // Miss sequencer with registered memory-port outputs and victim/refill latches.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      line_r       <= {LINE_ADDR_W{1'b0}};
      refill_r     <= {LINE_W{1'b0}};
      mem_enable_r <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_data_r   <= {LINE_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.cpu_req_i && !bus.sram_hit_i) begin
            line_r  <= bus.cpu_addr_i[ADDR_W-1:OFF_W];
            state_r <= ST_MISS;
          end
        end
        ST_MISS: begin
          mem_enable_r <= 1'b1;
          mem_data_r   <= bus.sram_data_i;
          // Only a valid victim carries data worth saving.
          if (bus.sram_tag_i[VALID_BIT] && bus.sram_tag_i[DIRTY_BIT]) begin
            mem_write_r <= 1'b1;
            mem_addr_r  <= {bus.sram_tag_i[TAG_W-1:0], line_r[IDX_W-1:0], 5'b00000};
            state_r     <= ST_WRITEBACK;
          end else begin
            mem_write_r <= 1'b0;
            mem_addr_r  <= {line_r, 5'b00000};
            state_r     <= ST_FETCH;
          end
        end
        ST_WRITEBACK: begin
          if (bus.mem_ack_i) begin
            mem_write_r <= 1'b0;
            mem_addr_r  <= {line_r, 5'b00000};
            state_r     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (bus.mem_ack_i) begin
            refill_r     <= bus.mem_data_i;
            mem_enable_r <= 1'b0;
            state_r      <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          state_r <= ST_IDLE;
        end
        default: begin
          mem_enable_r <= 1'b0;
          mem_write_r  <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
